fft_stage_feeder: RTL

- Upstream neighbour of the butterfly unit: collects a serial stream of N complex fixed-point samples into a local buffer.
- For one radix-2 FFT stage, it then issues the N/2 butterfly operand sets (a, b, twiddle w) over a val/rdy handshake.
- One instance per FFT stage; its output ports connect directly to the butterfly's ar/ac/br/bc/wr/wc inputs and handshake.

---
 rtl/fft_stage_feeder.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_stage_feeder.sv
// -----------------------------------------------------------------------------
// fft_stage_feeder
//
// Operand sequencer for one radix-2 FFT stage. It collects a frame of N
// complex samples from a serial val/rdy stream into a local buffer. It then
// issues the N/2 butterfly operand sets (a, b, twiddle w) for stage S over a
// second val/rdy handshake. Filling and issuing never overlap: the whole frame
// is accepted before the first pair goes out, and every pair is issued before
// the next frame is accepted.
//
// Parameters
//   n  : width of each real / imaginary word
//   d  : fractional bits (informational; values pass through bit-exact)
//   N  : FFT size in complex points (power of two, 4..256)
//   S  : stage index 0..log2(N)-1; the pair stride is half = 2^S
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   recv_val/rdy   sample stream handshake
//   recv_r/c       sample real / imaginary part
//   tw_r/c         flat twiddle tables; entry k at bits [k*n +: n]
//   send_val/rdy   operand-set handshake towards the butterfly
//   ar/ac, br/bc   operands a and b
//   wr/wc          twiddle w
//   pair_idx       index p of the pair on the outputs
//   last           high with send_val on the final pair (p = N/2-1)
//   All operand outputs, pair_idx and last read 0 while send_val is low.
//
// Build option
//   FFT_STAGE_FEEDER_BITREV_EN : when defined, sample number i is written to
//   buffer[bitrev(i)] (decimation-in-time input order for the stage-0
//   instance). When undefined, the natural-order write is used. Issue-side
//   addressing is the same either way.
// -----------------------------------------------------------------------------
module fft_stage_feeder #(
  parameter  int n   = 32,
  parameter  int d   = 16,
  parameter  int N   = 8,
  parameter  int S   = 0,
  localparam int LGN = $clog2(N),
  localparam int PW  = (LGN > 1) ? LGN - 1 : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               recv_val,
  output logic               recv_rdy,
  input  logic [n-1:0]       recv_r,
  input  logic [n-1:0]       recv_c,
  input  logic [n*N/2-1:0]   tw_r,
  input  logic [n*N/2-1:0]   tw_c,
  output logic               send_val,
  input  logic               send_rdy,
  output logic [n-1:0]       ar,
  output logic [n-1:0]       ac,
  output logic [n-1:0]       br,
  output logic [n-1:0]       bc,
  output logic [n-1:0]       wr,
  output logic [n-1:0]       wc,
  output logic [PW-1:0]      pair_idx,
  output logic               last
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (N < 4 || N > 256 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("fft_stage_feeder: N must be a power of two in 4..256");
  end
  if (S < 0 || S >= LGN) begin : g_bad_s
    $error("fft_stage_feeder: S must lie in 0..log2(N)-1");
  end
  if (d < 0 || d >= n) begin : g_bad_d
    $error("fft_stage_feeder: d must lie in 0..n-1");
  end

  // ---------------------------------------------------------------------------
  // Stage geometry
  // ---------------------------------------------------------------------------
  localparam int HALF = 1 << S;            // distance between a and b
  localparam int TW_SHIFT = LGN - 1 - S;   // log2(N / (2*half))

  localparam logic [LGN-1:0] HALF_BIT  = LGN'(HALF);
  localparam logic [LGN-1:0] HALF_MASK = LGN'(HALF - 1);
  localparam logic [PW-1:0]  P_MASK    = PW'(HALF - 1);
  localparam logic [PW-1:0]  P_LAST    = PW'(N / 2 - 1);
  localparam logic [LGN-1:0] W_LAST    = LGN'(N - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [LGN-1:0]  wcnt_q;
  logic [PW-1:0]   p_q;

  // Each entry packs {real, imag}.
  logic [2*n-1:0]  mem [N];

  logic            recv_fire;
  logic            send_fire;
  logic            p_is_last;
  logic [LGN-1:0]  wr_addr;
  logic [LGN-1:0]  p_ext;
  logic [LGN-1:0]  a_idx;
  logic [LGN-1:0]  b_idx;
  logic [PW-1:0]   k_idx;
  logic [n-1:0]    w_sel_r;
  logic [n-1:0]    w_sel_c;

  assign recv_rdy  = (state_q == FILL);
  assign send_val  = (state_q == ISSUE);
  assign recv_fire = recv_val & recv_rdy;
  assign send_fire = send_val & send_rdy;
  assign p_is_last = (p_q == P_LAST);

  // ---------------------------------------------------------------------------
  // Write addressing
  // ---------------------------------------------------------------------------
`ifdef FFT_STAGE_FEEDER_BITREV_EN
  function automatic logic [LGN-1:0] bitrev(input logic [LGN-1:0] x);
    logic [LGN-1:0] r;
    for (int i = 0; i < LGN; i++) begin
      r[i] = x[LGN-1-i];
    end
    return r;
  endfunction

  assign wr_addr = bitrev(wcnt_q);
`else
  assign wr_addr = wcnt_q;
`endif

  // ---------------------------------------------------------------------------
  // Issue addressing. With half a power of two, the division and modulo in
  // a_idx = (p / half) * 2*half + (p mod half) reduce to inserting a zero bit
  // at position S. b_idx then sets that bit. The twiddle index
  // (p mod half) * N/(2*half) is a left shift of the low S bits of p.
  // ---------------------------------------------------------------------------
  assign p_ext = {1'b0, p_q};
  assign a_idx = ((p_ext >> S) << (S + 1)) | (p_ext & HALF_MASK);
  assign b_idx = a_idx | HALF_BIT;
  assign k_idx = (p_q & P_MASK) << TW_SHIFT;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    w_sel_r = '0;
    w_sel_c = '0;
    for (int i = 0; i < N / 2; i++) begin
      if (k_idx == PW'(i)) begin
        w_sel_r = tw_r[i*n +: n];
        w_sel_c = tw_c[i*n +: n];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (recv_fire && wcnt_q == W_LAST) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (send_fire && p_is_last) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters. Both wrap to 0 at the end of their phase, so a new frame or a
  // new issue pass always starts from index 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
      p_q    <= '0;
    end else begin
      if (recv_fire) begin
        wcnt_q <= (wcnt_q == W_LAST) ? '0 : wcnt_q + 1'b1;
      end
      if (send_fire) begin
        p_q <= p_is_last ? '0 : p_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample buffer
  // ---------------------------------------------------------------------------
  // NOTE: the buffer is deliberately not reset. Every entry is rewritten
  // before it is read, and leaving it out of reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (recv_fire) begin
      mem[wr_addr] <= {recv_r, recv_c};
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage: operands are a pure function of the registered state,
  // so they hold still during backpressure. They are forced to 0 whenever
  // send_val is low, including immediately on asynchronous reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    ar       = '0;
    ac       = '0;
    br       = '0;
    bc       = '0;
    wr       = '0;
    wc       = '0;
    pair_idx = '0;
    last     = 1'b0;
    if (send_val) begin
      ar       = mem[a_idx][2*n-1:n];
      ac       = mem[a_idx][n-1:0];
      br       = mem[b_idx][2*n-1:n];
      bc       = mem[b_idx][n-1:0];
      wr       = w_sel_r;
      wc       = w_sel_c;
      pair_idx = p_q;
      last     = p_is_last;
    end
  end

endmodule
